// File: rtl/vga_pkg.sv
// Shared VGA drawing definitions: colour width, transparency code and the
// compositor's collision-tracking state encoding.
package vga_pkg;

    localparam int RGB_W = 8;
    localparam logic [RGB_W-1:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ARMED,
        HIT
    } comp_state_t;

endpackage

// File: rtl/layer_compositor_priority_select.sv
// Combinational fixed-priority colour mux: the lowest-index requesting layer
// wins; valid reports whether any layer requested.
module priority_select
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS = 4
) (
    input  logic [NUM_LAYERS-1:0]       req,
    input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
    output rgb_t                        color,
    output logic                        valid
);

    // Scan from lowest priority upward so the last assignment is the winner.
    always_comb begin
        color = '0;
        valid = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                color = layer_rgb[RGB_W*i +: RGB_W];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Pixel compositor and per-frame player-collision reporter.
// Optional build macro COMPOSITOR_HIT_COUNT_EN adds a saturating hitFrameCount.
module layer_compositor
    import vga_pkg::*;
#(
    parameter int   NUM_LAYERS     = 4,
    parameter rgb_t BACKGROUND_RGB = 8'h00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       drawingRequest,
    input  logic [RGB_W*NUM_LAYERS-1:0] layerRGB,
    output rgb_t                        RGBout,
    output logic                        collision,
    output logic [NUM_LAYERS-1:0]       collisionMask
`ifdef COMPOSITOR_HIT_COUNT_EN
    ,
    output logic [7:0]                  hitFrameCount
`endif
);

    rgb_t                  win_rgb;
    logic                  win_valid;
    logic [NUM_LAYERS-1:0] hit_vec;
    logic [NUM_LAYERS-1:0] acc_mask, acc_mask_next;
    logic [NUM_LAYERS-1:0] collision_mask_next;
    logic                  collision_next;
    comp_state_t           state, state_next;

    priority_select #(.NUM_LAYERS(NUM_LAYERS)) u_select (
        .req       (drawingRequest),
        .layer_rgb (layerRGB),
        .color     (win_rgb),
        .valid     (win_valid)
    );

    always_comb begin
        hit_vec    = drawingRequest & {NUM_LAYERS{drawingRequest[0]}};
        hit_vec[0] = 1'b0;
    end

    // A pixel sampled with startOfFrame opens the new frame, so its hits seed
    // the fresh mask while the old frame's mask is reported.
    always_comb begin
        state_next          = state;
        acc_mask_next       = acc_mask;
        collision_next      = 1'b0;
        collision_mask_next = collisionMask;
        case (state)
            WAIT_FRAME: begin
                if (startOfFrame) begin
                    acc_mask_next = hit_vec;
                    state_next    = (|hit_vec) ? HIT : ARMED;
                end
            end
            ARMED, HIT: begin
                if (startOfFrame) begin
                    collision_next      = (state == HIT);
                    collision_mask_next = (state == HIT) ? acc_mask : '0;
                    acc_mask_next       = hit_vec;
                    state_next          = (|hit_vec) ? HIT : ARMED;
                end else begin
                    acc_mask_next = acc_mask | hit_vec;
                    if (|hit_vec) state_next = HIT;
                end
            end
            default: state_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_FRAME;
            acc_mask      <= '0;
            collision     <= 1'b0;
            collisionMask <= '0;
            RGBout        <= BACKGROUND_RGB;
        end else begin
            state         <= state_next;
            acc_mask      <= acc_mask_next;
            collision     <= collision_next;
            collisionMask <= collision_mask_next;
            RGBout        <= win_valid ? win_rgb : BACKGROUND_RGB;
        end
    end

`ifdef COMPOSITOR_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hitFrameCount <= '0;
        end else if (collision && (hitFrameCount != 8'hFF)) begin
            hitFrameCount <= hitFrameCount + 8'd1;
        end
    end
`endif

endmodule
